// File: rtl/mips_fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment: hazard/redirect
// controls from ID, the instruction-memory port, and the IF/ID register outputs.
interface mips_fetch_stage_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;
   logic        fsm_state;     // 0 = RUN, 1 = HALTED

   // No valid/ready handshake: decode consumes IF/ID every cycle it is not
   // stalled, and if_id_valid=0 marks a bubble rather than back-pressure.
   modport master (
      input  stall, branch_taken, branch_target, jump, jump_target, imem_data,
      output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
             fault, fault_pc, fetch_count, fsm_state
   );

   modport slave (
      output stall, branch_taken, branch_target, jump, jump_target, imem_data,
      input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
             fault, fault_pc, fetch_count, fsm_state
   );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS program counter plus IF/ID pipeline register, with stall, branch/jump
// redirect, sticky fetch-fault halt and a retired-fetch counter.
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 256
) (
   input logic                clk,
   input logic                rst,
   mips_fetch_stage_if.master bus
);

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   // Compared in 33 bits so a PC+4 carry out of 32'hFFFF_FFFC reads as out of range.
   localparam logic [32:0] LAST_PC = 33'(IMEM_BYTES - 4);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] count_q, count_d;

   logic [32:0] pc_plus4;
   logic        redirect;
   logic [31:0] target;
   logic        target_bad;

   assign pc_plus4   = {1'b0, pc_q} + 33'd4;
   assign redirect   = bus.jump | bus.branch_taken;
   assign target     = bus.jump ? bus.jump_target : bus.branch_target;
   assign target_bad = (target[1:0] != 2'b00) || ({1'b0, target} > LAST_PC);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      count_d    = count_q;
      case (state_q)
         RUN: begin
            if (redirect) begin
               instr_d = 32'h0;
               pc4_d   = 32'h0;
               valid_d = 1'b0;
               if (target_bad) begin
                  state_d    = HALTED;
                  fault_d    = 1'b1;
                  fault_pc_d = target;
               end else begin
                  pc_d = target;
               end
            end else if (!bus.stall) begin
               instr_d = bus.imem_data;
               pc4_d   = pc_plus4[31:0];
               valid_d = 1'b1;
               count_d = count_q + 32'd1;
               // The word at the last legal PC is still delivered before halting.
               if (pc_plus4 > LAST_PC) begin
                  state_d    = HALTED;
                  fault_d    = 1'b1;
                  fault_pc_d = pc_plus4[31:0];
               end else begin
                  pc_d = pc_plus4[31:0];
               end
            end
         end
         HALTED: begin
            instr_d = 32'h0;
            valid_d = 1'b0;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         instr_q    <= 32'h0;
         pc4_q      <= 32'h0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0;
         count_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
         count_q    <= count_d;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.pc          = pc_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc4   = pc4_q;
   assign bus.if_id_valid = valid_q;
   assign bus.fault       = fault_q;
   assign bus.fault_pc    = fault_pc_q;
   assign bus.fetch_count = count_q;
   assign bus.fsm_state   = state_q;

endmodule
